// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single-word accesses onto a banked bit array.
// Define MEM_ACCESS_CTRL_INIT_EN to zero the whole array after reset.
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   req_valid/ready    request handshake; req_write selects write or read
//   req_addr           {bank,row,col}, bank in the MSBs
//   req_wdata/wmask    write data and per-bit write mask
//   rsp_valid/ready    read response handshake, rsp_rdata is the word
//   bank/row/col_select  array address
//   write_enable       per-bit array write strobe
//   data_in, data_out  array write data, array read data (combinational)
//   init_done          high once requests can be accepted
module mem_access_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int ROWS       = 64,
    parameter int COLS       = 64,
    parameter int DATA_WIDTH = 8,
    localparam int BW = $clog2(NUM_BANKS),
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS / DATA_WIDTH),
    localparam int AW = BW + RW + CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [BW-1:0]         bank_select,
    output logic [RW-1:0]         row_select,
    output logic [CW-1:0]         col_select,
    output logic [DATA_WIDTH-1:0] write_enable,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  init_done
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

`ifdef MEM_ACCESS_CTRL_INIT_EN
    localparam state_t RST_STATE = INIT;
    localparam int     NCOL      = COLS / DATA_WIDTH;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] wmask_q;
    logic                  hs;

    assign hs        = req_valid & req_ready;
    assign rsp_valid = (state == RESP);

`ifdef MEM_ACCESS_CTRL_INIT_EN
    // The sweep address is the select register itself, so the first
    // cell is written in the very first cycle after reset release.
    logic col_last;
    logic row_last;
    logic bank_last;
    logic sweep_last;

    assign col_last   = (col_select == CW'(NCOL - 1));
    assign row_last   = (row_select == RW'(ROWS - 1));
    assign bank_last  = (bank_select == BW'(NUM_BANKS - 1));
    assign sweep_last = col_last & row_last & bank_last;
`else
    assign init_done = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: begin
`ifdef MEM_ACCESS_CTRL_INIT_EN
                if (sweep_last) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            IDLE: begin
                if (hs) state_nxt = req_write ? WRITE : READ;
            end
            WRITE: state_nxt = IDLE;
            READ:  state_nxt = RESP;
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        write_enable = '0;
        if (state == WRITE) begin
            write_enable = wmask_q;
        end
`ifdef MEM_ACCESS_CTRL_INIT_EN
        // Reset holds the FSM in INIT; keep the strobe quiet until release.
        else if (state == INIT && rst) begin
            write_enable = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RST_STATE;
            req_ready   <= 1'b0;
            bank_select <= '0;
            row_select  <= '0;
            col_select  <= '0;
            data_in     <= '0;
            wmask_q     <= '0;
            rsp_rdata   <= '0;
`ifdef MEM_ACCESS_CTRL_INIT_EN
            init_done   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            // Ready is a registered copy of "next state is IDLE".
            req_ready <= (state_nxt == IDLE);
            if (hs) begin
                {bank_select, row_select, col_select} <= req_addr;
                if (req_write) begin
                    data_in <= req_wdata;
                    wmask_q <= req_wmask;
                end
            end
            if (state == READ) begin
                rsp_rdata <= data_out;
            end
`ifdef MEM_ACCESS_CTRL_INIT_EN
            if (state == INIT) begin
                if (sweep_last) begin
                    init_done <= 1'b1;
                end else if (col_last) begin
                    col_select <= '0;
                    if (row_last) begin
                        row_select  <= '0;
                        bank_select <= bank_select + BW'(1);
                    end else begin
                        row_select <= row_select + RW'(1);
                    end
                end else begin
                    col_select <= col_select + CW'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a
// behavioural bit array hanging off the select/strobe outputs.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic [1:0]  bank_select;
    logic [5:0]  row_select;
    logic [2:0]  col_select;
    logic [7:0]  write_enable;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        init_done;

    int n_chk;
    int n_fail;

    logic [7:0] arr     [0:2047];
    logic [7:0] exp_mem [0:2047];
    logic [7:0] exp_q   [$];

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .bank_select  (bank_select),
        .row_select   (row_select),
        .col_select   (col_select),
        .write_enable (write_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] sel;
    assign sel      = {bank_select, row_select, col_select};
    assign data_out = arr[sel];

    initial begin
        for (int i = 0; i < 2048; i++) arr[i] <= 8'hA5;
    end

    always @(posedge clk) begin
        arr[sel] <= (arr[sel] & ~write_enable) | (data_in & write_enable);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input bit wr, input logic [10:0] a,
                        input logic [7:0] d, input logic [7:0] m);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) chk("req_timeout", 32'(ok), 1);
        else if (wr) exp_mem[a] = (exp_mem[a] & ~m) | (d & m);
        else exp_q.push_back(exp_mem[a]);
    endtask

    task automatic chk_rst();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_selects", 32'(sel), 0);
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_data_in", 32'(data_in), 0);
    endtask

    task automatic wait_init();
`ifdef MEM_ACCESS_CTRL_INIT_EN
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        chk("init_done_rst", 32'(init_done), 0);
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                chk("init_we", 32'(write_enable), 32'hFF);
                chk("init_ready", 32'(req_ready), 0);
            end
            done = init_done;
        end
        chk("init_cycles", 32'(n), 2048);
        for (int i = 0; i < 2048; i++) exp_mem[i] = 8'h00;
`else
        chk("init_done_const", 32'(init_done), 1);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] a;
        int          seen;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2048; i++) exp_mem[i] = 8'hA5;

        repeat (2) @(posedge clk);
        #1;
        chk_rst();
        rst = 1'b1;
        wait_init();

        // write 0x1A5 then read it back, check latency
        send(1'b1, 11'h1A5, 8'h3C, 8'hFF);
        chk("wr_sel", 32'(sel), 32'h1A5);
        chk("wr_we", 32'(write_enable), 32'hFF);
        chk("wr_data_in", 32'(data_in), 32'h3C);
        chk("wr_ready", 32'(req_ready), 0);
        send(1'b0, 11'h1A5, 8'h00, 8'h00);
        chk("rd_valid_early", 32'(rsp_valid), 0);
        chk("rd_we", 32'(write_enable), 0);
        chk("rd_sel", 32'(sel), 32'h1A5);
        @(posedge clk);
        #1;
        chk("rsp_latency", 32'(rsp_valid), 1);

        // partial mask, then a zero mask that must change nothing
        send(1'b1, 11'h000, 8'hFF, 8'hFF);
        send(1'b1, 11'h000, 8'h00, 8'h0F);
        send(1'b1, 11'h000, 8'h55, 8'h00);
        chk("zero_mask_we", 32'(write_enable), 0);
        send(1'b0, 11'h000, 8'h00, 8'h00);
        chk("mask_model", 32'(exp_mem[11'h000]), 32'hF0);

        // response back-pressure
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(1'b0, 11'h1A5, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_rdata), 32'(exp_mem[11'h1A5]));
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 32'(rsp_valid), 0);
        chk("release_idle", 32'(req_ready), 1);

        // back-to-back writes at the address extremes
        send(1'b1, 11'h7FF, 8'h5A, 8'hFF);
        chk("b2b_bank_hi", 32'(bank_select), 3);
        chk("b2b_gap", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        chk("b2b_ready", 32'(req_ready), 1);
        send(1'b1, 11'h000, 8'hC3, 8'hFF);
        chk("b2b_bank_lo", 32'(bank_select), 0);
        send(1'b0, 11'h7FF, 8'h00, 8'h00);
        send(1'b0, 11'h000, 8'h00, 8'h00);

        // mixed random traffic
        for (int i = 0; i < 16; i++) begin
            a = 11'($urandom_range(0, 2047));
            send(1'(i % 2 == 0), a, 8'($urandom), 8'($urandom));
            if (i % 2 == 0) send(1'b0, a, 8'h00, 8'h00);
        end

        // reset in the middle of a read
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 11'h7FF, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        chk_rst();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        wait_init();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            seen = seen | 32'(rsp_valid);
        end
        chk("no_rsp_after_rst", 32'(seen), 0);

        send(1'b0, 11'h1A5, 8'h00, 8'h00);
        send(1'b0, 11'h155, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
